// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for DIGITS common-select 7-segment digits. A hex
// value (plus per-digit decimal points) is captured into a shadow register on
// `load` and copied into the display register only when the scan wraps from
// the last digit back to digit 0, so a frame never shows a mix of old and new
// digits. Each digit owns SLOT_CYCLES clocks. The first BLANK_CYCLES clocks
// of every slot keep all selects inactive to avoid ghosting between digits.
//
// Ports
//   clk             system clock
//   rst             asynchronous reset, active-high
//   value           4*DIGITS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp              per-digit decimal point, captured together with value
//   digit_en        live per-digit enable (0 = digit dark), not latched
//   load            1-cycle strobe capturing {dp,value} into the shadow register
//   io_7seg_select  digit select, one-hot when active (polarity SEL_ACT_LOW)
//   io_7seg         {dp,g,f,e,d,c,b,a} (polarity SEG_ACT_LOW)
//   frame_done      1-cycle pulse when the scan wraps from digit DIGITS-1 to 0
//
// Optional feature
//   LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//   nonzero nibble of the displayed value are dark (digit 0 always shown).
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 25000,
  parameter int BLANK_CYCLES = 250,
  parameter int SEL_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     io_7seg_select,
  output logic [7:0]            io_7seg,
  output logic                  frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Polarity is applied by XOR with the "all off" pattern.
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  // Hex digit to active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic                tick;
  logic                frame_end;
  logic [DIGITS-1:0]   suppress;
  logic [3:0]          nib_p0;
  logic                pt_p0;
  logic                on_p0;
  logic                lit_p0;
  logic [DIGITS-1:0]   sel_p0;
  logic [7:0]          seg_p0;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Scan timing and value buffering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
      end
      // A load landing on the frame boundary goes straight to the display so
      // that the new value is not delayed by a whole frame.
      if (frame_end) begin
        disp_val <= load ? value : shadow_val;
        disp_dp  <= load ? dp    : shadow_dp;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; everything above the first nonzero nibble
  // is suppressed. Digit 0 is excluded so a zero value still shows "0".
  logic seen_nz;
  always_comb begin
    suppress = '0;
    seen_nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp_val[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      suppress[i] = ~seen_nz;
    end
  end
`else
  assign suppress = '0;
`endif

  // Digit selection and decode for the current slot
  always_comb begin
    nib_p0 = 4'h0;
    pt_p0  = 1'b0;
    on_p0  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_p0 = disp_val[4*i +: 4];
        pt_p0  = disp_dp[i];
        on_p0  = digit_en[i] & ~suppress[i];
      end
    end
    lit_p0 = on_p0 && (cnt >= CNT_BLANK);
    sel_p0 = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_p0[i] = lit_p0 && (idx == IDX_W'(i));
    end
    seg_p0 = lit_p0 ? {pt_p0, seg_decode(nib_p0)} : 8'h00;
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_7seg_select <= SEL_OFF;
      io_7seg        <= SEG_OFF;
      frame_done     <= 1'b0;
    end else begin
      io_7seg_select <= sel_p0 ^ SEL_OFF;
      io_7seg        <= seg_p0 ^ SEG_OFF;
      frame_done     <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Randomized bench for seg7_scan_driver (DIGITS=4, SLOT_CYCLES=8,
// BLANK_CYCLES=2, active-low outputs). The reference model tracks only the
// number of clock edges since reset plus the shadow/display contents; slot
// position and digit index are derived arithmetically from the edge count.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  io_7seg_select;
  logic [7:0]  io_7seg;
  logic        frame_done;

  seg7_scan_driver #(
    .DIGITS      (DIGITS),
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK),
    .SEL_ACT_LOW (1),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .value         (value),
    .dp            (dp),
    .digit_en      (digit_en),
    .load          (load),
    .io_7seg_select(io_7seg_select),
    .io_7seg       (io_7seg),
    .frame_done    (frame_done)
  );

  always #5 if (clk_en) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Active-high segment table from the character set.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state
  int          k;
  logic [15:0] m_sh_val, m_disp_val;
  logic [3:0]  m_sh_dp, m_disp_dp;

  task automatic model_reset();
    k          = 0;
    m_sh_val   = '0;
    m_disp_val = '0;
    m_sh_dp    = '0;
    m_disp_dp  = '0;
  endtask

  function automatic logic [3:0] nibble_of(input logic [15:0] v, input int d);
    logic [15:0] t;
    t = v >> (4 * d);
    return t[3:0];
  endfunction

  function automatic bit digit_shown(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int top;
    top = 0;
    for (int i = 0; i < DIGITS; i++)
      if (nibble_of(m_disp_val, i) != 4'h0) top = i;
    return (d <= top);
`else
    return (d >= 0);
`endif
  endfunction

  // One clock: predict outputs for the coming edge, advance the model,
  // clock the DUT and compare on the falling edge.
  task automatic step();
    int          pos, d;
    bit          lit;
    logic [3:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fd;
    pos   = k % SLOT;
    d     = (k / SLOT) % DIGITS;
    lit   = (pos >= BLANK) && digit_en[d] && digit_shown(d);
    e_sel = lit ? ~(4'b0001 << d) : 4'hF;
    e_seg = lit ? ~{m_disp_dp[d], seg_tab[nibble_of(m_disp_val, d)]} : 8'hFF;
    e_fd  = ((k % FRAME) == FRAME - 1);
    if (e_fd) begin
      m_disp_val = load ? value : m_sh_val;
      m_disp_dp  = load ? dp    : m_sh_dp;
    end
    if (load) begin
      m_sh_val = value;
      m_sh_dp  = dp;
    end
    k++;
    @(posedge clk);
    @(negedge clk);
    chk("select", 32'(io_7seg_select), 32'(e_sel));
    chk("segments", 32'(io_7seg), 32'(e_seg));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] p);
    value = v;
    dp    = p;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    value    = '0;
    dp       = '0;
    digit_en = 4'hF;
    load     = 1'b0;

    // Reset with no clock running
    #1 rst = 1'b1;
    #1;
    chk("reset_select", 32'(io_7seg_select), 32'h0000_000F);
    chk("reset_segments", 32'(io_7seg), 32'h0000_00FF);
    chk("reset_frame_done", 32'(frame_done), 32'h0);

    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Basic value, shows after first frame boundary
    load_once(16'h1234, 4'h0);
    run(2 * FRAME + 5);

    // Mid-frame load must wait for the boundary
    while ((k % FRAME) != 10) step();
    load_once(16'hABCD, 4'b0110);
    run(2 * FRAME);

    // Partial enable
    digit_en = 4'b0101;
    run(FRAME + 7);

    // Load coinciding with a frame boundary
    digit_en = 4'hF;
    while ((k % FRAME) != FRAME - 1) step();
    load_once(16'h0070, 4'b0011);
    run(FRAME + 3);
    while ((k % FRAME) != FRAME - 1) step();
    load_once(16'h0000, 4'b0000);
    run(FRAME + 3);

    // Randomized traffic: values, dp, enables and load strobes
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom);
      value = 16'($urandom) & ({$urandom_range(0, 1) ? 16'hFFFF : 16'h00FF});
      dp    = 4'($urandom);
      load  = ($urandom_range(0, 15) == 0);
      step();
    end
    load = 1'b0;

    // Asynchronous reset mid-slot while a digit is lit
    digit_en = 4'hF;
    load_once(16'h8888, 4'hF);
    while (!(((k % FRAME) >= FRAME) || ((k / SLOT) % DIGITS == 1 && (k % SLOT) == 5))) step();
    #2 rst = 1'b1;
    #1;
    chk("midreset_select", 32'(io_7seg_select), 32'h0000_000F);
    chk("midreset_segments", 32'(io_7seg), 32'h0000_00FF);
    chk("midreset_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(FRAME + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
